// File: rtl/arm_multicycle.sv
// Multicycle ARM subset core (ADD/SUB/AND/ORR, LDR/STR imm offset, B) with one shared memory port.
// Latency: DP 4, LDR 5, STR 4, B 3, condition-fail/illegal 2 cycles; +1 per memory wait cycle.
// Backpressure: FETCH/MEMRD/MEMWR hold mem_req and address/data stable until mem_ready.
// Ports: clk, reset (async active-low); mem_req/mem_we/mem_addr/mem_wdata out, mem_rdata/mem_ready in;
//        PC = current program counter; illegal = sticky unsupported-encoding flag.
module arm_multicycle #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic [31:0]       PC,
  output logic              illegal
);

  typedef enum logic [3:0] {
    FETCH, DECODE, EXECR, EXECI, ALUWB, MEMADR, MEMRD, MEMWB, MEMWR, BRANCH
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, instr_q, instr_d;
  logic [31:0] a_q, a_d, b_q, b_d;      // Rn operand; Rm (DP reg form) or Rd (store data)
  logic [31:0] res_q, res_d;            // ALU result, then memory address, then load data
  logic [1:0]  cv_q, cv_d;              // adder carry/overflow captured in EXEC
  logic [3:0]  nzcv_q, nzcv_d;
  logic        illegal_q, illegal_d;
  logic [31:0] rf_q [16];               // entry 15 unused: R15 is the PC
  logic        rf_we;
  logic        req_c, we_c;
  logic [31:0] addr_c;

  // Instruction fields
  logic [3:0]  cond, opc, rn, rd;
  logic        i_bit, s_bit, u_bit, l_bit;
  logic        dp_ok, mem_ok, br_ok, legal;
  assign cond  = instr_q[31:28];
  assign i_bit = instr_q[25];
  assign opc   = instr_q[24:21];
  assign s_bit = instr_q[20];
  assign u_bit = instr_q[23];
  assign l_bit = instr_q[20];
  assign rn    = instr_q[19:16];
  assign rd    = instr_q[15:12];

  assign dp_ok  = (instr_q[27:26] == 2'b00)
                && (opc == 4'b0000 || opc == 4'b0010 || opc == 4'b0100 || opc == 4'b1100)
                && (i_bit ? (instr_q[11:8] == 4'd0) : (instr_q[11:4] == 8'd0));
  // Word, immediate offset, pre-indexed without writeback only
  assign mem_ok = (instr_q[27:26] == 2'b01) && !instr_q[25] && instr_q[24]
                && !instr_q[22] && !instr_q[21];
  assign br_ok  = (instr_q[27:24] == 4'b1010);
  assign legal  = (dp_ok || mem_ok || br_ok) && (cond != 4'hF);

  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    {n, z, cf, v} = f;
    case (c)
      4'h0: cond_pass = z;
      4'h1: cond_pass = !z;
      4'h2: cond_pass = cf;
      4'h3: cond_pass = !cf;
      4'h4: cond_pass = n;
      4'h5: cond_pass = !n;
      4'h6: cond_pass = v;
      4'h7: cond_pass = !v;
      4'h8: cond_pass = cf && !z;
      4'h9: cond_pass = !cf || z;
      4'hA: cond_pass = (n == v);
      4'hB: cond_pass = (n != v);
      4'hC: cond_pass = !z && (n == v);
      4'hD: cond_pass = z || (n != v);
      4'hE: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  endfunction

  // R15 reads see the fetched address + 8; pc_q already holds fetched + 4
  function automatic logic [31:0] rd_reg(input logic [3:0] idx, input logic [31:0] pc,
                                          input logic [31:0] val);
    rd_reg = (idx == 4'd15) ? pc + 32'd4 : val;
  endfunction

  // ALU
  logic [31:0] opb, opb_x, alu_res;
  logic [32:0] sum;
  logic        is_sub, ovf, is_logic;
  assign opb      = (state_q == EXECI) ? {24'd0, instr_q[7:0]} : b_q;
  assign is_sub   = (opc == 4'b0010);
  assign is_logic = (opc == 4'b0000) || (opc == 4'b1100);
  assign opb_x    = is_sub ? ~opb : opb;
  assign sum      = {1'b0, a_q} + {1'b0, opb_x} + {32'd0, is_sub};
  assign ovf      = (a_q[31] == opb_x[31]) && (sum[31] != a_q[31]);
  always_comb begin
    case (opc)
      4'b0000: alu_res = a_q & opb;
      4'b1100: alu_res = a_q | opb;
      default: alu_res = sum[31:0];
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    cv_d      = cv_q;
    nzcv_d    = nzcv_q;
    illegal_d = illegal_q;
    rf_we     = 1'b0;
    req_c     = 1'b0;
    we_c      = 1'b0;
    addr_c    = pc_q;
    case (state_q)
      FETCH: begin
        req_c = 1'b1;
        if (mem_ready) begin
          instr_d = mem_rdata;
          pc_d    = pc_q + 32'd4;
          state_d = DECODE;
        end
      end
      DECODE: begin
        a_d = rd_reg(rn, pc_q, rf_q[rn]);
        b_d = (dp_ok && !i_bit) ? rd_reg(instr_q[3:0], pc_q, rf_q[instr_q[3:0]])
                                : rd_reg(rd, pc_q, rf_q[rd]);
        if (!legal) begin
          illegal_d = 1'b1;
          state_d   = FETCH;
        end else if (!cond_pass(cond, nzcv_q)) state_d = FETCH;
        else if (br_ok)  state_d = BRANCH;
        else if (mem_ok) state_d = MEMADR;
        else if (i_bit)  state_d = EXECI;
        else             state_d = EXECR;
      end
      EXECR, EXECI: begin
        res_d   = alu_res;
        cv_d    = {sum[32], ovf};
        state_d = ALUWB;
      end
      ALUWB: begin
        if (rd == 4'd15) pc_d = res_q;
        else             rf_we = 1'b1;
        if (s_bit) nzcv_d = {res_q[31], res_q == 32'd0, is_logic ? nzcv_q[1:0] : cv_q};
        state_d = FETCH;
      end
      MEMADR: begin
        res_d   = u_bit ? a_q + {20'd0, instr_q[11:0]} : a_q - {20'd0, instr_q[11:0]};
        state_d = l_bit ? MEMRD : MEMWR;
      end
      MEMRD: begin
        req_c  = 1'b1;
        addr_c = res_q;
        if (mem_ready) begin
          res_d   = mem_rdata;
          state_d = MEMWB;
        end
      end
      MEMWB: begin
        if (rd == 4'd15) pc_d = res_q;
        else             rf_we = 1'b1;
        state_d = FETCH;
      end
      MEMWR: begin
        req_c  = 1'b1;
        we_c   = 1'b1;
        addr_c = res_q;
        if (mem_ready) state_d = FETCH;
      end
      BRANCH: begin
        pc_d    = pc_q + 32'd4 + {{6{instr_q[23]}}, instr_q[23:0], 2'b00};
        state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= FETCH;
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      cv_q      <= '0;
      nzcv_q    <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      a_q       <= a_d;
      b_q       <= b_d;
      res_q     <= res_d;
      cv_q      <= cv_d;
      nzcv_q    <= nzcv_d;
      illegal_q <= illegal_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) rf_q[i] <= '0;
    end else if (rf_we) begin
      rf_q[rd] <= res_q;
    end
  end

  // Reset input gates the request so a pending access drops in the same cycle
  assign mem_req   = reset && req_c;
  assign mem_we    = reset && we_c;
  assign mem_addr  = addr_c[ADDR_W-1:0];
  assign mem_wdata = b_q;
  assign PC        = pc_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_arm_multicycle.sv
module tb_arm_multicycle;
  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, PC;
  logic        illegal;

  always #5 clk = ~clk;

  arm_multicycle dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .PC(PC),
    .illegal(illegal)
  );

  logic [31:0] mem [256];
  int          cyc = 0, wait_cnt = 0, n_wr = 0;
  int          n_err = 0, n_chk = 0;
  bit          stall = 1'b0;
  int          fetch_cyc [256];
  logic [3:0]  nzcv_at [256];
  logic        ill_at [256];

  // Data region 0x40..0x7F answers after 3 wait cycles; code is zero-wait
  function automatic bit is_data(input logic [31:0] a);
    return (a >= 32'h40) && (a < 32'h80);
  endfunction

  assign mem_rdata = mem[mem_addr[9:2]];
  always_comb mem_ready = mem_req && !stall && (!is_data(mem_addr) || wait_cnt >= 3);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    wait_cnt <= (mem_req && !mem_ready) ? wait_cnt + 1 : 0;
    if (mem_req && mem_we && mem_ready) begin
      mem[mem_addr[9:2]] <= mem_wdata;
      n_wr <= n_wr + 1;
    end
  end

  // Record when each code word is fetched, plus the architectural flags at that point
  always @(negedge clk) begin
    if (mem_req && !mem_we && mem_ready && !is_data(mem_addr)) begin
      fetch_cyc[mem_addr[9:2]] = cyc;
      nzcv_at[mem_addr[9:2]]   = dut.nzcv_q;
      ill_at[mem_addr[9:2]]    = illegal;
    end
    if (mem_req && mem_we) begin
      check("st_addr", mem_addr, 32'h40);
      check("st_data", mem_wdata, 32'd5);
    end
  end

  // {from word, to word, expected cycles}
  int lat_tab [14][3] = '{
    '{0, 1, 4},   '{1, 2, 4},   '{2, 6, 3},   '{6, 7, 7},   '{7, 8, 8},
    '{8, 9, 2},   '{9, 10, 2},  '{10, 11, 4}, '{11, 12, 4}, '{12, 13, 4},
    '{13, 14, 4}, '{14, 34, 4}, '{34, 35, 4}, '{35, 36, 2}
  };
  // {register, expected value}
  logic [31:0] reg_tab [11][2] = '{
    '{1, 5}, '{2, 0}, '{3, 5}, '{4, 0}, '{5, 0}, '{6, 10}, '{7, 2},
    '{8, 32'hF2}, '{9, 32'hFFFF_FFFF}, '{10, 7}, '{0, 0}
  };

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = 32'h0;
      fetch_cyc[i] = -1;
      nzcv_at[i] = 4'h0;
      ill_at[i] = 1'b0;
    end
    mem[0]  = 32'hE280_1005;  // ADD  R1,R0,#5
    mem[1]  = 32'hE251_2005;  // SUBS R2,R1,#5
    mem[2]  = 32'h0A00_0002;  // BEQ  0x18
    mem[3]  = 32'hE280_5009;  // ADD  R5,R0,#9 (skipped)
    mem[4]  = 32'hE280_5009;
    mem[5]  = 32'hE280_5009;
    mem[6]  = 32'hE580_1040;  // STR  R1,[R0,#0x40]
    mem[7]  = 32'hE590_3040;  // LDR  R3,[R0,#0x40]
    mem[8]  = 32'h1284_4001;  // ADDNE R4,R4,#1 (Z=1, skipped)
    mem[9]  = 32'hE7F0_00F0;  // undefined
    mem[10] = 32'hE081_6001;  // ADD  R6,R1,R1
    mem[11] = 32'hE216_7003;  // ANDS R7,R6,#3
    mem[12] = 32'hE387_80F0;  // ORR  R8,R7,#0xF0
    mem[13] = 32'hE250_9001;  // SUBS R9,R0,#1
    mem[14] = 32'hE28F_F048;  // ADD  R15,R15,#0x48 -> 0x88
    mem[34] = 32'h4280_A007;  // ADDMI R10,R0,#7
    mem[35] = 32'h5A00_0010;  // BPL  (N=1, skipped)

    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req", {31'd0, mem_req}, 32'd0);
    check("rst_we", {31'd0, mem_we}, 32'd0);
    check("rst_pc", PC, 32'h0);
    check("rst_ill", {31'd0, illegal}, 32'd0);
    @(posedge clk);
    #2 reset = 1'b1;
    repeat (120) @(negedge clk);

    foreach (lat_tab[i])
      check($sformatf("lat_%0h", lat_tab[i][0] * 4),
            fetch_cyc[lat_tab[i][1]] - fetch_cyc[lat_tab[i][0]], lat_tab[i][2]);
    check("skip_0c", fetch_cyc[3], 32'hFFFF_FFFF);
    check("flags_beq", {28'd0, nzcv_at[6]}, 32'h6);
    check("flags_ands", {28'd0, nzcv_at[13]}, 32'h2);
    check("flags_end", {28'd0, dut.nzcv_q}, 32'h8);
    check("ill_before", {31'd0, ill_at[9]}, 32'd0);
    check("ill_after", {31'd0, ill_at[10]}, 32'd1);
    check("ill_sticky", {31'd0, illegal}, 32'd1);
    check("mem_40", mem[16], 32'd5);
    check("n_writes", n_wr, 32'd1);
    foreach (reg_tab[i])
      check($sformatf("r%0d", reg_tab[i][0]), dut.rf_q[reg_tab[i][0][3:0]], reg_tab[i][1]);

    // Reset while a fetch is stalled
    stall = 1'b1;
    repeat (3) @(negedge clk);
    check("stall_req", {31'd0, mem_req}, 32'd1);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("arst_req", {31'd0, mem_req}, 32'd0);
    check("arst_pc", PC, 32'h0);
    check("arst_ill", {31'd0, illegal}, 32'd0);
    @(posedge clk);
    #2 reset = 1'b1;
    stall = 1'b0;
    #1;
    check("rel_req", {31'd0, mem_req}, 32'd1);
    check("rel_addr", mem_addr, 32'h0);
    check("rel_we", {31'd0, mem_we}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
